// File: rtl/uart_rx_core_if.sv
// Receive-side handshake bundle between uart_rx_core (master) and the host RX buffer (slave).
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output data_out, valid, frame_err, parity_err,
    input  ready
  );

  modport slave (
    input  data_out, valid, frame_err, parity_err,
    output ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: 2-flop input synchroniser, 3-sample majority vote per bit,
// optional run-time parity, 1 or 2 stop bits, valid/ready output, sticky overrun, break detect.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | line idle, waiting for a tick with rx_s low
// START    | validating the start bit (false start returns to IDLE)
// DATA     | shifting in DATA_BITS data bits, LSB first
// PARITY   | capturing the parity bit (only when the latched mode is odd/even)
// STOP     | checking stop bit(s); leaves on the last stop bit's decision tick
// BRK_WAIT | break seen, waiting for the line to return high
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_tick,
  input  logic           rx,
  input  logic [1:0]     parity_mode,
  uart_rx_core_if.master rx_if,
  output logic           overrun,
  input  logic           err_clr,
  output logic           break_det,
  output logic           busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [CW-1:0] CNT_S0  = CW'(M - 1);
  localparam logic [CW-1:0] CNT_S1  = CW'(M);
  localparam logic [CW-1:0] CNT_DEC = CW'(M + 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, rx_s_q, rx_s_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 par_bit_q, par_bit_d;
  logic                 any_one_q, any_one_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, fe_q, fe_d, pe_q, pe_d;
  logic                 overrun_q, overrun_d, brk_q, brk_d, busy_q, busy_d;

  logic maj, commit, fe_new, pe_new, ovr_set;

  // Next-state logic: synchroniser, bit timing, frame FSM, commit/handshake and overrun.
  always_comb begin
    sync1_d    = rx;
    rx_s_d     = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    par_bit_d  = par_bit_q;
    any_one_d  = any_one_q;
    stop_bad_d = stop_bad_q;
    stop_idx_d = stop_idx_q;
    data_d     = data_q;
    valid_d    = valid_q;
    fe_d       = fe_q;
    pe_d       = pe_q;
    overrun_d  = overrun_q;
    brk_d      = 1'b0;
    commit     = 1'b0;
    fe_new     = 1'b0;
    ovr_set    = 1'b0;

    maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    unique case (par_mode_q)
      2'b01:   pe_new = ~(^shift_q ^ par_bit_q);
      2'b10:   pe_new = ^shift_q ^ par_bit_q;
      default: pe_new = 1'b0;
    endcase

    if (baud_tick) begin
      if (cnt_q == CNT_S0) samp_d[0] = rx_s_q;
      if (cnt_q == CNT_S1) samp_d[1] = rx_s_q;
      if (state_q != IDLE && state_q != BRK_WAIT)
        cnt_d = (cnt_q == CNT_END) ? '0 : cnt_q + 1'b1;

      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            cnt_d   = CW'(1);
          end
        end
        START: begin
          if (cnt_q == CNT_DEC) begin
            if (maj) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              par_mode_d = parity_mode;
              bit_idx_d  = '0;
              any_one_d  = 1'b0;
              stop_bad_d = 1'b0;
              stop_idx_d = 1'b0;
            end
          end else if (cnt_q == CNT_END) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (cnt_q == CNT_DEC) begin
            shift_d   = {maj, shift_q[DATA_BITS-1:1]};
            any_one_d = any_one_q | maj;
          end
          if (cnt_q == CNT_END) begin
            if (bit_idx_q == LAST_BIT)
              state_d = (par_mode_q == 2'b01 || par_mode_q == 2'b10) ? PARITY : STOP;
            else
              bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == CNT_DEC) begin
            par_bit_d = maj;
            any_one_d = any_one_q | maj;
          end
          if (cnt_q == CNT_END) state_d = STOP;
        end
        STOP: begin
          if (cnt_q == CNT_DEC) begin
            if (STOP_BITS == 2 && !stop_idx_q) begin
              // first of two stop bits: record it and run the full period
              stop_idx_d = 1'b1;
              stop_bad_d = ~maj;
              any_one_d  = any_one_q | maj;
            end else begin
              // last stop bit: leave half a bit early to resync on the next start edge
              cnt_d = '0;
              if (maj && !stop_bad_q) begin
                commit  = 1'b1;
                state_d = IDLE;
              end else if (any_one_q || maj) begin
                commit  = 1'b1;
                fe_new  = 1'b1;
                state_d = IDLE;
              end else begin
                brk_d   = 1'b1;
                state_d = BRK_WAIT;
              end
            end
          end
        end
        BRK_WAIT: begin
          if (rx_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (valid_q && rx_if.ready) valid_d = 1'b0;
    if (commit) begin
      if (!valid_q || rx_if.ready) begin
        data_d  = shift_q;
        fe_d    = fe_new;
        pe_d    = pe_new;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    if (ovr_set)      overrun_d = 1'b1;
    else if (err_clr) overrun_d = 1'b0;

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      par_mode_q <= 2'b00;
      par_bit_q  <= 1'b0;
      any_one_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      overrun_q  <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      par_bit_q  <= par_bit_d;
      any_one_q  <= any_one_d;
      stop_bad_q <= stop_bad_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      overrun_q  <= overrun_d;
      brk_q      <= brk_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_if.data_out   = data_q;
  assign rx_if.valid      = valid_q;
  assign rx_if.frame_err  = fe_q;
  assign rx_if.parity_err = pe_q;
  assign overrun          = overrun_q;
  assign break_det        = brk_q;
  assign busy             = busy_q;
endmodule
